// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller.
// Holds the FSM state enum, x0 constant, fwd_sel encoding and SELW helper.
package hazard_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam logic [4:0] X0 = 5'd0;

    // fwd_sel encoding: SEL_RF reads the register file, k+1 forwards
    // from forwarding stage k.
    localparam int SEL_RF = 0;

    function automatic int sel_w(input int fwd_stages);
        return $clog2(fwd_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// master: pipeline side (drives register numbers/enables), slave: controller.
interface hazard_ctrl_if #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 3,
    parameter int SELW       = hazard_pkg::sel_w(FWD_STAGES)
);
    logic [NUM_SRC*5-1:0]    rs_ex;
    logic [NUM_SRC*5-1:0]    rs_id;
    logic [FWD_STAGES*5-1:0] rd_stage;
    logic [FWD_STAGES-1:0]   regwen_stage;
    logic [4:0]              rd_ex;
    logic                    regwen_ex;
    logic                    memrd_ex;
    logic                    branch_taken_ex;

    logic [NUM_SRC*SELW-1:0] fwd_sel;
    logic                    stall_if;
    logic                    stall_id;
    logic                    flush_id;
    logic                    flush_ex;
    logic                    busy;
    logic [31:0]             stall_cnt;

    modport master (
        output rs_ex, rs_id, rd_stage, regwen_stage,
        output rd_ex, regwen_ex, memrd_ex, branch_taken_ex,
        input  fwd_sel, stall_if, stall_id, flush_id, flush_ex,
        input  busy, stall_cnt
    );

    modport slave (
        input  rs_ex, rs_id, rd_stage, regwen_stage,
        input  rd_ex, regwen_ex, memrd_ex, branch_taken_ex,
        output fwd_sel, stall_if, stall_id, flush_id, flush_ex,
        output busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_fwd_prio.sv
// Per-operand forwarding priority encoder; youngest matching stage wins.
// Ports: rs_i source reg, rd_stage_i/regwen_stage_i per stage, sel_o fwd_sel.
module fwd_prio
    import hazard_pkg::*;
#(
    parameter int FWD_STAGES = 3,
    parameter int SELW       = sel_w(FWD_STAGES)
) (
    input  logic [4:0]              rs_i,
    input  logic [FWD_STAGES*5-1:0] rd_stage_i,
    input  logic [FWD_STAGES-1:0]   regwen_stage_i,
    output logic [SELW-1:0]         sel_o
);

    // Walk oldest to youngest so the lowest matching index ends up last.
    always_comb begin
        sel_o = SELW'(SEL_RF);
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (regwen_stage_i[k] && rs_i != X0 &&
                rd_stage_i[5*k +: 5] == rs_i) begin
                sel_o = SELW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside EX: operand forwarding, load-use / interlock
// stalls, taken-branch flush and a saturating stall-cycle counter.
// Ports: clk, reset (sync, active-high), hif (slave modport of
// hazard_ctrl_if carrying all register numbers, enables and controls).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int FWD_EN     = 1
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hif
);

    localparam int SELW = sel_w(FWD_STAGES);
    localparam int CNTW = $clog2(LOAD_LAT + 1);
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LOAD_LAT - 1);

    state_e                  state_q, state_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [31:0]             stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC*SELW-1:0] sel_raw;
    logic [4:0]              rs;
    logic                    lu, lu_fwd, lu_ilk;
    logic                    stall, brflush;
    logic                    stall_id;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
        fwd_prio #(
            .FWD_STAGES(FWD_STAGES),
            .SELW      (SELW)
        ) u_prio (
            .rs_i          (hif.rs_ex[5*i +: 5]),
            .rd_stage_i    (hif.rd_stage),
            .regwen_stage_i(hif.regwen_stage),
            .sel_o         (sel_raw[SELW*i +: SELW])
        );
    end

    // lu_fwd: only a load in EX can't be forwarded in time.
    // lu_ilk: without forwarding every in-flight writer is a hazard.
    always_comb begin
        lu_fwd = 1'b0;
        lu_ilk = 1'b0;
        rs     = X0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs = hif.rs_id[5*i +: 5];
            if (rs != X0 && hif.regwen_ex && rs == hif.rd_ex) begin
                lu_fwd = lu_fwd | hif.memrd_ex;
                lu_ilk = 1'b1;
            end
            for (int k = 0; k < FWD_STAGES; k++) begin
                if (rs != X0 && hif.regwen_stage[k] &&
                    rs == hif.rd_stage[5*k +: 5]) begin
                    lu_ilk = 1'b1;
                end
            end
        end
        lu = (FWD_EN != 0) ? lu_fwd : lu_ilk;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        brflush = 1'b0;
        if (hif.branch_taken_ex) begin
            brflush = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (FWD_EN == 0) begin
            stall = lu;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lu) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                STALL: begin
                    stall = 1'b1;
                    // cnt_q == 1 marks the final stall cycle.
                    if (cnt_q <= CNTW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign stall_id = !reset && stall;

    assign hif.stall_if  = stall_id;
    assign hif.stall_id  = stall_id;
    assign hif.flush_id  = !reset && brflush;
    assign hif.flush_ex  = !reset && (brflush || stall);
    assign hif.busy      = !reset && (state_q == STALL);
    assign hif.fwd_sel   = (FWD_EN != 0 && !reset) ? sel_raw : '0;
    assign hif.stall_cnt = stall_cnt_q;

    assign stall_cnt_d = (stall_id && stall_cnt_q != '1) ?
                         stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    a_cnt_no_underflow: assert property (
        @(posedge clk) disable iff (reset)
        state_q == STALL |-> cnt_q != '0
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances cover LOAD_LAT=2,
// LOAD_LAT=4 and interlock-only mode.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [4:0] obs;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.NUM_SRC(2), .FWD_STAGES(3)) a ();
    hazard_ctrl_if #(.NUM_SRC(2), .FWD_STAGES(3)) b ();
    hazard_ctrl_if #(.NUM_SRC(2), .FWD_STAGES(3)) c ();

    hazard_ctrl #(.NUM_SRC(2), .FWD_STAGES(3), .LOAD_LAT(2), .FWD_EN(1))
        u_a (.clk(clk), .reset(reset), .hif(a));
    hazard_ctrl #(.NUM_SRC(2), .FWD_STAGES(3), .LOAD_LAT(4), .FWD_EN(1))
        u_b (.clk(clk), .reset(reset), .hif(b));
    hazard_ctrl #(.NUM_SRC(2), .FWD_STAGES(3), .LOAD_LAT(1), .FWD_EN(0))
        u_c (.clk(clk), .reset(reset), .hif(c));

    task automatic clr();
        a.rs_ex = '0; a.rs_id = '0; a.rd_stage = '0; a.regwen_stage = '0;
        a.rd_ex = '0; a.regwen_ex = 0; a.memrd_ex = 0; a.branch_taken_ex = 0;
        b.rs_ex = '0; b.rs_id = '0; b.rd_stage = '0; b.regwen_stage = '0;
        b.rd_ex = '0; b.regwen_ex = 0; b.memrd_ex = 0; b.branch_taken_ex = 0;
        c.rs_ex = '0; c.rs_id = '0; c.rd_stage = '0; c.regwen_stage = '0;
        c.rd_ex = '0; c.regwen_ex = 0; c.memrd_ex = 0; c.branch_taken_ex = 0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Load r7 in EX, ID reads r7 as operand 1.
    task automatic lu_a(input logic on);
        a.memrd_ex = on; a.regwen_ex = on;
        a.rd_ex = on ? 5'd7 : 5'd0;
        a.rs_id = {5'd7, 5'd2};
    endtask

    task automatic test_reset();
        clr();
        reset = 1'b1;
        a.rs_ex = {5'd5, 5'd5}; a.rd_stage = {5'd5, 5'd5, 5'd5};
        a.regwen_stage = 3'b111;
        lu_a(1'b1);
        a.branch_taken_ex = 1'b1;
        @(negedge clk);
        #1;
        obs = {a.stall_if, a.stall_id, a.flush_id, a.flush_ex, a.busy};
        tests++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 00000", obs);
        end
        tests++;
        if (a.fwd_sel !== 4'b0000) begin
            fails++;
            $display("FAIL reset_fwd: got %b want 0000", a.fwd_sel);
        end
        tests++;
        if (a.stall_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d want 0", a.stall_cnt);
        end
        clr();
        reset = 1'b0;
    endtask

    task automatic test_fwd();
        logic [3:0] exp [5];
        logic [2:0] wen [5];
        logic [14:0] rd [5];
        logic [9:0] rs [5];
        wen = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b111};
        rd  = '{{5'd5, 5'd5, 5'd5}, {5'd5, 5'd5, 5'd5}, {5'd5, 5'd5, 5'd5},
                {5'd5, 5'd5, 5'd5}, {5'd5, 5'd5, 5'd0}};
        rs  = '{{5'd9, 5'd5}, {5'd5, 5'd5}, {5'd5, 5'd5},
                {5'd5, 5'd5}, {5'd5, 5'd0}};
        exp = '{4'b0001, 4'b1010, 4'b1111, 4'b0000, 4'b1000};
        do_reset();
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            a.regwen_stage = wen[v]; a.rd_stage = rd[v]; a.rs_ex = rs[v];
            #1;
            tests++;
            if (a.fwd_sel !== exp[v]) begin
                fails++;
                $display("FAIL fwd_v%0d: got %b want %b", v, a.fwd_sel, exp[v]);
            end
        end
        tests++;
        if (a.stall_id !== 1'b0) begin
            fails++;
            $display("FAIL fwd_nostall: got %b want 0", a.stall_id);
        end
        clr();
    endtask

    task automatic test_load_use();
        do_reset();
        lu_a(1'b1);
        #1;
        obs = {a.stall_if, a.stall_id, a.flush_id, a.flush_ex, a.busy};
        tests++;
        if (obs !== 5'b11010) begin
            fails++;
            $display("FAIL lu_c1: got %b want 11010", obs);
        end
        @(negedge clk);
        lu_a(1'b0);
        #1;
        obs = {a.stall_if, a.stall_id, a.flush_id, a.flush_ex, a.busy};
        tests++;
        if (obs !== 5'b11011) begin
            fails++;
            $display("FAIL lu_c2: got %b want 11011", obs);
        end
        @(negedge clk);
        #1;
        obs = {a.stall_if, a.stall_id, a.flush_id, a.flush_ex, a.busy};
        tests++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("FAIL lu_c3: got %b want 00000", obs);
        end
        tests++;
        if (a.stall_cnt !== 32'd2) begin
            fails++;
            $display("FAIL lu_cnt: got %0d want 2", a.stall_cnt);
        end
        clr();
    endtask

    task automatic test_back_to_back();
        do_reset();
        lu_a(1'b1);
        for (int cy = 0; cy < 4; cy++) begin
            #1;
            obs = {a.stall_if, a.stall_id, a.flush_id, a.flush_ex, a.busy};
            tests++;
            if (obs !== {4'b1101, 1'(cy % 2)}) begin
                fails++;
                $display("FAIL b2b_c%0d: got %b want %b", cy, obs,
                         {4'b1101, 1'(cy % 2)});
            end
            @(negedge clk);
        end
        clr();
        #1;
        tests++;
        if (a.stall_cnt !== 32'd4 || a.busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got cnt %0d busy %b want 4 0",
                     a.stall_cnt, a.busy);
        end
    endtask

    task automatic test_branch();
        do_reset();
        lu_a(1'b1);
        a.branch_taken_ex = 1'b1;
        #1;
        obs = {a.stall_if, a.stall_id, a.flush_id, a.flush_ex, a.busy};
        tests++;
        if (obs !== 5'b00110) begin
            fails++;
            $display("FAIL br_ctl: got %b want 00110", obs);
        end
        @(negedge clk);
        clr();
        #1;
        tests++;
        if (a.busy !== 1'b0 || a.stall_cnt !== 32'd0) begin
            fails++;
            $display("FAIL br_after: got busy %b cnt %0d want 0 0",
                     a.busy, a.stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        b.memrd_ex = 1; b.regwen_ex = 1; b.rd_ex = 5'd4;
        b.rs_id = {5'd0, 5'd4};
        #1;
        obs = {b.stall_if, b.stall_id, b.flush_id, b.flush_ex, b.busy};
        tests++;
        if (obs !== 5'b11010) begin
            fails++;
            $display("FAIL rms_c1: got %b want 11010", obs);
        end
        @(negedge clk);
        b.memrd_ex = 0; b.regwen_ex = 0; b.rd_ex = 5'd0;
        #1;
        obs = {b.stall_if, b.stall_id, b.flush_id, b.flush_ex, b.busy};
        tests++;
        if (obs !== 5'b11011) begin
            fails++;
            $display("FAIL rms_c2: got %b want 11011", obs);
        end
        reset = 1'b1;
        #1;
        obs = {b.stall_if, b.stall_id, b.flush_id, b.flush_ex, b.busy};
        tests++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("FAIL rms_inrst: got %b want 00000", obs);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        obs = {b.stall_if, b.stall_id, b.flush_id, b.flush_ex, b.busy};
        tests++;
        if (obs !== 5'b00000 || b.stall_cnt !== 32'd0) begin
            fails++;
            $display("FAIL rms_post: got %b cnt %0d want 00000 0",
                     obs, b.stall_cnt);
        end
        @(negedge clk);
        #1;
        obs = {b.stall_if, b.stall_id, b.flush_id, b.flush_ex, b.busy};
        tests++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("FAIL rms_resid: got %b want 00000", obs);
        end
    endtask

    task automatic test_interlock();
        do_reset();
        c.rd_stage = {5'd3, 5'd0, 5'd0};
        c.regwen_stage = 3'b100;
        c.rs_id = {5'd0, 5'd3};
        c.rs_ex = {5'd0, 5'd3};
        for (int cy = 0; cy < 3; cy++) begin
            #1;
            obs = {c.stall_if, c.stall_id, c.flush_id, c.flush_ex, c.busy};
            tests++;
            if (obs !== 5'b11010 || c.fwd_sel !== 4'b0000) begin
                fails++;
                $display("FAIL ilk_c%0d: got %b sel %b want 11010 0000",
                         cy, obs, c.fwd_sel);
            end
            @(negedge clk);
        end
        c.regwen_stage = 3'b000;
        #1;
        obs = {c.stall_if, c.stall_id, c.flush_id, c.flush_ex, c.busy};
        tests++;
        if (obs !== 5'b00000 || c.stall_cnt !== 32'd3) begin
            fails++;
            $display("FAIL ilk_drop: got %b cnt %0d want 00000 3",
                     obs, c.stall_cnt);
        end
        c.regwen_ex = 1; c.rd_ex = 5'd3;
        #1;
        tests++;
        if (c.stall_id !== 1'b1) begin
            fails++;
            $display("FAIL ilk_rdex: got %b want 1", c.stall_id);
        end
        clr();
    endtask

    task automatic test_saturate();
        do_reset();
        force u_a.stall_cnt_d = 32'hFFFF_FFFE;
        @(negedge clk);
        release u_a.stall_cnt_d;
        #1;
        tests++;
        if (a.stall_cnt !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL sat_pre: got %h want fffffffe", a.stall_cnt);
        end
        lu_a(1'b1);
        @(negedge clk);
        #1;
        tests++;
        if (a.stall_cnt !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL sat_1: got %h want ffffffff", a.stall_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        clr();
        #1;
        tests++;
        if (a.stall_cnt !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL sat_3: got %h want ffffffff", a.stall_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        clr();
        test_reset();
        test_fwd();
        test_load_use();
        test_back_to_back();
        test_branch();
        test_reset_mid_stall();
        test_interlock();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
